// File: rtl/velocity_updater_pkg.sv
// Shared constants, record layout and FSM state type for the velocity updater.
// Also hosts the 33-bit to 32-bit clamp used when VU_SATURATE_EN is defined.
package velocity_updater_pkg;

    localparam int REC_W     = 97;
    localparam int COMP_W    = 32;
    localparam int VALID_BIT = 96;
    localparam int X_LSB     = 0;
    localparam int Y_LSB     = 32;
    localparam int Z_LSB     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vu_state_t;

    // Top two bits disagreeing means the 33-bit sum left the 32-bit signed range.
    function automatic logic [COMP_W-1:0] clamp33(input logic [COMP_W:0] sum);
        logic [COMP_W-1:0] res;
        case (sum[COMP_W:COMP_W-1])
            2'b01:   res = 32'h7FFF_FFFF;
            2'b10:   res = 32'h8000_0000;
            default: res = sum[COMP_W-1:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/velocity_updater_if.sv
// Cache-side bus of one velocity updater: start/done handshake, velocity and
// force read port, velocity write port.
interface velocity_updater_if;
    import velocity_updater_pkg::*;

    logic              ready;
    logic              double_buffer;
    logic [31:0]       raddr;
    logic [REC_W-1:0]  rdata_v;
    logic [REC_W-1:0]  rdata_f;
    logic [31:0]       waddr;
    logic [REC_W-1:0]  wdata_v;
    logic              we;
    logic              done;

    modport master (
        output ready, double_buffer, rdata_v, rdata_f,
        input  raddr, waddr, wdata_v, we, done
    );

    modport slave (
        input  ready, double_buffer, rdata_v, rdata_f,
        output raddr, waddr, wdata_v, we, done
    );

endinterface

// File: rtl/velocity_updater_axis_lane.sv
// One axis of the update v + ((f * DT_M) >>> FRAC_BITS): multiply stage, then add stage.
// VU_SATURATE_EN selects clamping of the sum; otherwise the sum wraps.
module vu_axis_lane
    import velocity_updater_pkg::*;
#(
    parameter int                 FRAC_BITS = 16,
    parameter logic signed [31:0] DT_M      = 32'sh0000_8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COMP_W-1:0] i_v,
    input  logic [COMP_W-1:0] i_f,
    output logic [COMP_W-1:0] o_sum
);

    logic signed [63:0] w_prod;
    logic signed [63:0] r_prod;
    logic [COMP_W-1:0]  r_v;
    logic [COMP_W:0]    w_s33;
    logic [COMP_W:0]    w_sum;
    logic [COMP_W-1:0]  w_res;
    logic [COMP_W-1:0]  r_sum;

    assign w_prod = $signed({{32{i_f[31]}}, i_f}) * $signed({{32{DT_M[31]}}, DT_M});
    assign w_s33  = 33'(r_prod >>> FRAC_BITS);
    assign w_sum  = {r_v[COMP_W-1], r_v} + w_s33;

`ifdef VU_SATURATE_EN
    assign w_res = clamp33(w_sum);
`else
    logic w_unused_msb;
    assign w_unused_msb = w_sum[COMP_W];
    assign w_res        = w_sum[COMP_W-1:0];
`endif

    // Multiply stage registers product and the matching velocity; add stage registers the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod <= 64'sd0;
            r_v    <= 32'd0;
            r_sum  <= 32'd0;
        end else begin
            r_prod <= w_prod;
            r_v    <= i_v;
            r_sum  <= w_res;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/velocity_updater.sv
// Per-cell velocity update walk: reads records, adds force*DT_M in place, raises done.
// Optional clamp of the sum under VU_SATURATE_EN (latency unchanged).
module velocity_updater
    import velocity_updater_pkg::*;
#(
    parameter int                 MAX_PARTICLES = 64,
    parameter int                 FRAC_BITS     = 16,
    parameter logic signed [31:0] DT_M          = 32'sh0000_8000
) (
    input  logic               clk,
    input  logic               reset,
    velocity_updater_if.slave  bus
);

    vu_state_t         r_state;
    vu_state_t         w_next;
    logic              w_start;
    logic              w_stop;
    logic [31:0]       r_raddr;
    logic              r_issue;
    logic              r_v1;
    logic [31:0]       r_a1;
    logic              r_v2;
    logic [31:0]       r_a2;
    logic              r_we;
    logic [31:0]       r_waddr;
    logic              r_done;
    logic              w_s1_live;
    logic              w_term;
    logic              w_last;
    logic [COMP_W-1:0] w_x;
    logic [COMP_W-1:0] w_y;
    logic [COMP_W-1:0] w_z;
    logic              w_unused_fvalid;

    assign w_unused_fvalid = bus.rdata_f[VALID_BIT];
    assign w_s1_live       = r_v1 & bus.rdata_v[VALID_BIT];
    assign w_term          = r_v1 & ~bus.rdata_v[VALID_BIT];
    assign w_last          = (r_raddr[30:0] == 31'(MAX_PARTICLES - 1));

    // Next-state decode; w_start loads slot 0, w_stop ends issuing.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_stop  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.ready) begin
                    w_next  = RUN;
                    w_start = 1'b1;
                end else begin
                    w_next  = r_state;
                end
            end
            RUN: begin
                if (w_term || w_last) begin
                    w_next = DRAIN;
                    w_stop = 1'b1;
                end else begin
                    w_next = RUN;
                end
            end
            DRAIN: begin
                if (!r_v1 && !r_v2) begin
                    w_next = DONE;
                end else begin
                    w_next = DRAIN;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Address issue, valid/address pipeline alongside the lanes, and write-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_raddr <= 32'd0;
            r_issue <= 1'b0;
            r_v1    <= 1'b0;
            r_a1    <= 32'd0;
            r_v2    <= 1'b0;
            r_a2    <= 32'd0;
            r_we    <= 1'b0;
            r_waddr <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == DONE);
            if (w_start) begin
                r_raddr <= {bus.double_buffer, 31'd0};
                r_issue <= 1'b1;
            end else if (w_stop) begin
                r_issue <= 1'b0;
            end else if (r_issue) begin
                r_raddr <= {r_raddr[31], r_raddr[30:0] + 31'd1};
            end else begin
                r_raddr <= r_raddr;
            end
            // A terminating record squashes the speculative read issued in the same cycle.
            r_v1 <= r_issue & ~w_term;
            r_a1 <= r_raddr;
            r_v2 <= w_s1_live;
            r_a2 <= r_a1;
            r_we <= r_v2;
            if (r_v2) begin
                r_waddr <= r_a2;
            end else begin
                r_waddr <= r_waddr;
            end
        end
    end

    vu_axis_lane #(.FRAC_BITS(FRAC_BITS), .DT_M(DT_M)) u_lane_x (
        .clk(clk), .reset(reset),
        .i_v(bus.rdata_v[X_LSB +: COMP_W]), .i_f(bus.rdata_f[X_LSB +: COMP_W]), .o_sum(w_x)
    );
    vu_axis_lane #(.FRAC_BITS(FRAC_BITS), .DT_M(DT_M)) u_lane_y (
        .clk(clk), .reset(reset),
        .i_v(bus.rdata_v[Y_LSB +: COMP_W]), .i_f(bus.rdata_f[Y_LSB +: COMP_W]), .o_sum(w_y)
    );
    vu_axis_lane #(.FRAC_BITS(FRAC_BITS), .DT_M(DT_M)) u_lane_z (
        .clk(clk), .reset(reset),
        .i_v(bus.rdata_v[Z_LSB +: COMP_W]), .i_f(bus.rdata_f[Z_LSB +: COMP_W]), .o_sum(w_z)
    );

    assign bus.raddr   = r_raddr;
    assign bus.waddr   = r_waddr;
    assign bus.we      = r_we;
    assign bus.done    = r_done;
    assign bus.wdata_v = {r_we, w_z, w_y, w_x};

endmodule

// File: tb/tb_velocity_updater.sv
// Directed bench for velocity_updater (MAX_PARTICLES=8): cache model with 1-cycle read,
// write scoreboard, immediate-assertion checks. Honours VU_SATURATE_EN for expectations.
module tb_velocity_updater;
    import velocity_updater_pkg::*;

    localparam int          MAXP = 8;
    localparam logic [31:0] DT   = 32'h0000_8000;

    typedef struct packed {
        logic [31:0] addr;
        logic [96:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    velocity_updater_if bus();

    velocity_updater #(.MAX_PARTICLES(MAXP), .FRAC_BITS(16), .DT_M(DT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    wr_t         sb[$];
    logic [96:0] mem_v [0:MAXP-1];
    logic [96:0] mem_f [0:MAXP-1];
    int          checks       = 0;
    int          errors       = 0;
    int          cyc          = 0;
    int          n_wr         = 0;
    int          first_we_cyc = -1;
    int          acc_cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus.rdata_v <= mem_v[bus.raddr[2:0]];
        bus.rdata_f <= mem_f[bus.raddr[2:0]];
    end

    task automatic chk(input string tag, input logic [96:0] obs, input logic [96:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [96:0] rec(input logic vld, input logic [31:0] z,
                                        input logic [31:0] y, input logic [31:0] x);
        return {vld, z, y, x};
    endfunction

    function automatic logic [31:0] axis_model(input logic [31:0] v, input logic [31:0] f);
        longint             p;
        logic signed [32:0] s;
        logic signed [32:0] sum;
        p   = longint'($signed(f)) * longint'($signed(DT));
        s   = 33'(p >>> 16);
        sum = 33'($signed(v)) + s;
`ifdef VU_SATURATE_EN
        if (sum > 33'sh0_7FFF_FFFF) return 32'h7FFF_FFFF;
        if (sum < -33'sh0_8000_0000) return 32'h8000_0000;
`endif
        return sum[31:0];
    endfunction

    task automatic push_wr(input logic [31:0] a, input logic [96:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_model(input logic bank);
        for (int i = 0; i < MAXP; i++) begin
            if (!mem_v[i][96]) break;
            push_wr({bank, 31'(i)}, rec(1'b1,
                axis_model(mem_v[i][95:64], mem_f[i][95:64]),
                axis_model(mem_v[i][63:32], mem_f[i][63:32]),
                axis_model(mem_v[i][31:0],  mem_f[i][31:0])));
        end
    endtask

    task automatic start_walk(input logic bank, input string tag);
        n_wr         = 0;
        first_we_cyc = -1;
        @(negedge clk);
        bus.double_buffer = bank;
        bus.ready         = 1'b1;
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
        acc_cyc   = cyc;
        chk({tag, "_first_raddr"}, 97'(bus.raddr), 97'({bank, 31'd0}));
        chk({tag, "_done_low"}, 97'(bus.done), 97'(1'b0));
    endtask

    task automatic wait_done(input int bound, input string tag);
        bit got = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_done_seen"}, 97'(got), 97'(1'b1));
        chk({tag, "_sb_empty"}, 97'(sb.size()), 97'(0));
    endtask

    // Write monitor: every we must match the oldest expected write; raddr stays in range.
    always @(negedge clk) begin
        if (reset) begin
            chk("raddr_in_range", 97'(bus.raddr[30:0] < 31'(MAXP)), 97'(1'b1));
            if (bus.we === 1'b1) begin
                if (first_we_cyc < 0) first_we_cyc = cyc;
                n_wr++;
                chk("write_expected", 97'(sb.size() != 0), 97'(1'b1));
                if (sb.size() != 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("waddr", 97'(bus.waddr), 97'(e.addr));
                    chk("wdata_v", bus.wdata_v, e.data);
                end
            end
        end
    end

    initial begin
        bus.ready         = 1'b0;
        bus.double_buffer = 1'b0;
        for (int i = 0; i < MAXP; i++) begin
            mem_v[i] = '0;
            mem_f[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_raddr", 97'(bus.raddr), 97'(0));
        chk("rst_waddr", 97'(bus.waddr), 97'(0));
        chk("rst_wdata", bus.wdata_v, 97'(0));
        chk("rst_we", 97'(bus.we), 97'(0));
        chk("rst_done", 97'(bus.done), 97'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_done", 97'(bus.done), 97'(0));
        chk("idle_we", 97'(bus.we), 97'(0));

        // 1: three valid particles, slot 3 terminates, later slots must be squashed
        for (int i = 0; i < MAXP; i++) begin
            mem_v[i] = rec(i < 3 || i > 3, 32'h0, 32'h0, 32'h0001_0000);
            mem_f[i] = rec(1'b0, 32'h0, 32'h0, 32'h0002_0000);
        end
        for (int i = 0; i < 3; i++) push_wr(32'(i), rec(1'b1, 32'h0, 32'h0, 32'h0002_0000));
        start_walk(1'b0, "t1");
        wait_done(20, "t1");
        chk("t1_nwrites", 97'(n_wr), 97'(3));
        chk("t1_latency", 97'(first_we_cyc), 97'(acc_cyc + 3));

        // 2: empty cell
        mem_v[0] = rec(1'b0, 32'h0, 32'h0, 32'h0);
        start_walk(1'b0, "t2");
        wait_done(4, "t2");
        chk("t2_nwrites", 97'(n_wr), 97'(0));

        // 3 and 5: overflow, floor rounding of a negative product, underflow
        mem_v[0] = rec(1'b1, 32'h8000_0000, 32'h0000_1234, 32'h7FFF_0000);
        mem_f[0] = rec(1'b0, 32'hFFFE_0000, 32'hFFFE_0000, 32'h0002_0000);
        mem_v[1] = rec(1'b1, 32'h0, 32'h0, 32'h0);
        mem_f[1] = rec(1'b0, 32'h0001_0000, 32'h0, 32'hFFFF_FFFF);
        mem_v[2] = rec(1'b0, 32'h0, 32'h0, 32'h0);
`ifdef VU_SATURATE_EN
        push_wr(32'd0, rec(1'b1, 32'h8000_0000, 32'hFFFF_1234, 32'h7FFF_FFFF));
`else
        push_wr(32'd0, rec(1'b1, 32'h7FFF_0000, 32'hFFFF_1234, 32'h8000_0000));
`endif
        push_wr(32'd1, rec(1'b1, 32'h0000_8000, 32'h0, 32'hFFFF_FFFF));
        start_walk(1'b0, "t3");
        wait_done(20, "t3");
        chk("t3_nwrites", 97'(n_wr), 97'(2));

        // 4: full cell stops at MAX_PARTICLES; a ready pulse mid-walk is ignored
        for (int i = 0; i < MAXP; i++) begin
            mem_v[i] = rec(1'b1, $urandom, $urandom, $urandom);
            mem_f[i] = rec(1'b0, $urandom, $urandom, $urandom);
        end
        push_model(1'b0);
        start_walk(1'b0, "t4");
        @(negedge clk);
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
        wait_done(30, "t4");
        chk("t4_nwrites", 97'(n_wr), 97'(MAXP));

        // 6: reset mid-walk, then restart in bank 1
        for (int i = 0; i < MAXP; i++) mem_v[i][96] = (i < 6);
        push_model(1'b0);
        start_walk(1'b0, "t6");
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #3;
            if (n_wr >= 2) break;
        end
        chk("t6_two_writes", 97'(n_wr >= 2), 97'(1'b1));
        reset = 1'b0;
        #1;
        chk("t6_rst_we", 97'(bus.we), 97'(0));
        chk("t6_rst_done", 97'(bus.done), 97'(0));
        chk("t6_rst_raddr", 97'(bus.raddr), 97'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < MAXP; i++) mem_v[i][96] = (i < 2);
        push_model(1'b1);
        start_walk(1'b1, "t6b");
        wait_done(20, "t6b");
        chk("t6b_nwrites", 97'(n_wr), 97'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
